// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// presents pc/instr to IF/ID, holding one buffered word under stall and killing stale fetches.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic [31:0] kill_pc, kill_pc_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] pc_out_n, instr_out_n;
  logic        valid_out_n;
  logic [31:0] target;
  logic        unused_pc_bits;

  assign target         = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign imem_req       = (state == FETCH);
  assign imem_addr      = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      kill_pc    <= 32'h0;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
      pc_out     <= 32'h0;
      instr_out  <= 32'h0;
      valid_out  <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      kill       <= kill_n;
      kill_pc    <= kill_pc_n;
      hold_pc    <= hold_pc_n;
      hold_instr <= hold_instr_n;
      pc_out     <= pc_out_n;
      instr_out  <= instr_out_n;
      valid_out  <= valid_out_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    kill_n       = kill;
    kill_pc_n    = kill_pc;
    hold_pc_n    = hold_pc;
    hold_instr_n = hold_instr;
    pc_out_n     = pc_out;
    instr_out_n  = instr_out;
    valid_out_n  = valid_out;

    case (state)
      IDLE: begin
        state_n = FETCH;
        if (redirect) begin
          pc_n        = target;
          valid_out_n = 1'b0;
          instr_out_n = 32'h0;
        end
      end

      FETCH: begin
        if (redirect) begin
          valid_out_n = 1'b0;
          instr_out_n = 32'h0;
          if (imem_ack) begin
            pc_n   = target;
            kill_n = 1'b0;
          end else begin
            // Request is still outstanding: keep the address stable and retarget later.
            kill_n    = 1'b1;
            kill_pc_n = target;
          end
        end else if (imem_ack) begin
          if (kill) begin
            pc_n   = kill_pc;
            kill_n = 1'b0;
          end else if (!stall) begin
            pc_out_n    = pc;
            instr_out_n = imem_rdata;
            valid_out_n = 1'b1;
            pc_n        = pc + 32'd4;
          end else begin
            hold_pc_n    = pc;
            hold_instr_n = imem_rdata;
            pc_n         = pc + 32'd4;
            state_n      = HOLD;
          end
        end else if (!stall) begin
          valid_out_n = 1'b0;
          instr_out_n = 32'h0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_n        = target;
          valid_out_n = 1'b0;
          instr_out_n = 32'h0;
          state_n     = FETCH;
        end else if (!stall) begin
          pc_out_n    = hold_pc;
          instr_out_n = hold_instr;
          valid_out_n = 1'b1;
          state_n     = FETCH;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM word[i]=i with programmable wait, a queue-based model of the
// fetch stage checked every cycle, plus literal expectations at key points.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .valid_out  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int wait_cycles = 0;
  int wcnt = 0;

  // Model: next fetch address, a pending redirect target for an uncancellable
  // request, a one-deep queue of fetched-but-unpresented words, and the outputs.
  logic        m_started;
  logic [31:0] m_addr;
  logic        m_has_pend;
  logic [31:0] m_pend;
  logic [63:0] m_buf[$];
  logic [31:0] e_pc, e_instr;
  logic        e_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic m_req();
    return m_started && (m_buf.size() == 0);
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_addr = 32'h0; m_has_pend = 1'b0; m_pend = 32'h0;
    m_buf.delete();
    e_pc = 32'h0; e_instr = 32'h0; e_valid = 1'b0;
  endtask

  task automatic present(input logic [31:0] p, input logic [31:0] i);
    e_pc = p; e_instr = i; e_valid = 1'b1;
  endtask

  task automatic flush();
    e_valid = 1'b0; e_instr = 32'h0;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] tgt,
                            input logic ack, input logic [31:0] rdata);
    logic [63:0] w;
    logic        busy;
    busy = m_req();
    if (!m_started) begin
      m_started = 1'b1;
      if (rd) begin m_addr = tgt; flush(); end
    end else if (rd) begin
      flush();
      if (!busy) begin m_buf.delete(); m_addr = tgt; end
      else if (ack) begin m_addr = tgt; m_has_pend = 1'b0; end
      else begin m_has_pend = 1'b1; m_pend = tgt; end
    end else if (!busy) begin
      if (!st) begin w = m_buf.pop_front(); present(w[63:32], w[31:0]); end
    end else if (ack) begin
      if (m_has_pend) begin m_addr = m_pend; m_has_pend = 1'b0; end
      else begin
        if (st) m_buf.push_back({m_addr, rdata});
        else present(m_addr, rdata);
        m_addr = m_addr + 32'd4;
      end
    end else if (!st) begin
      flush();
    end
  endtask

  // One clock cycle: drive inputs and memory, check request side, step model, check outputs.
  task automatic run_cycle(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    if (imem_req) begin
      imem_ack   = (wcnt >= wait_cycles);
      imem_rdata = imem_ack ? (imem_addr >> 2) : 32'hDEAD_BEEF;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) chk("imem_addr", imem_addr, m_addr);
    model_step(st, rd, {rpc[31:2], 2'b00}, imem_ack, imem_rdata);
    if (imem_req && !imem_ack) wcnt++; else wcnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("valid_out", 32'(valid_out), 32'(e_valid));
    chk("pc_out", pc_out, e_pc);
    chk("instr_out", instr_out, e_instr);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; wcnt = 0;
    model_reset();
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 32'(valid_out), 32'h0);
    imem_ack = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int vcount;
    logic [31:0] first_addr;
    logic        got_addr;

    // Zero-wait ROM from reset, then a 3-cycle stall with a buffered word
    wait_cycles = 0;
    do_reset();
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("c1_valid", 32'(valid_out), 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("c2_valid", 32'(valid_out), 32'h1);
    chk("c2_pc", pc_out, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("c3_instr", instr_out, 32'h1);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("c4_pc", pc_out, 32'h8);
    run_cycle(1'b1, 1'b0, 32'h0);
    chk("hold_req", 32'(imem_req), 32'h0);
    chk("hold_pc", pc_out, 32'h8);
    run_cycle(1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h0);
    chk("hold_pc_late", pc_out, 32'h8);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("release_pc", pc_out, 32'hC);
    chk("release_instr", instr_out, 32'h3);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("after_release_pc", pc_out, 32'h10);

    // Two-cycle memory wait: one valid per three cycles
    wait_cycles = 2;
    vcount = 0;
    for (int i = 0; i < 9; i++) begin
      run_cycle(1'b0, 1'b0, 32'h0);
      if (valid_out) vcount++;
    end
    chk("wait2_valid_count", 32'(vcount), 32'd3);

    // Redirect while the fetch of 0x20 is outstanding
    n = 0;
    while (!(imem_req && imem_addr == 32'h20 && wcnt == 0) && n < 200) begin
      run_cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("reach_0x20", 32'(n < 200), 32'h1);
    run_cycle(1'b0, 1'b1, 32'h0000_0103);
    chk("redir_flush", 32'(valid_out), 32'h0);
    n = 0; got_addr = 1'b0; first_addr = 32'h0;
    while (!valid_out && n < 50) begin
      if (imem_req && imem_addr != 32'h20 && !got_addr) begin
        first_addr = imem_addr; got_addr = 1'b1;
      end
      run_cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("redir_first_addr", first_addr, 32'h100);
    chk("redir_latency", 32'(n), 32'd5);
    chk("redir_pc", pc_out, 32'h100);
    chk("redir_instr", instr_out, 32'h40);

    // Redirect and stall together in HOLD
    wait_cycles = 0;
    run_cycle(1'b1, 1'b0, 32'h0);
    chk("hold2_req", 32'(imem_req), 32'h0);
    run_cycle(1'b1, 1'b1, 32'h0000_0200);
    chk("hold_redir_valid", 32'(valid_out), 32'h0);
    chk("hold_redir_instr", instr_out, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("hold_redir_pc", pc_out, 32'h200);
    chk("hold_redir_word", instr_out, 32'h80);

    // PC wrap at the top of the address space
    run_cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_instr", instr_out, 32'h3FFF_FFFF);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("wrap_next_pc", pc_out, 32'h0);

    // Reset asserted in the middle of a memory wait
    wait_cycles = 3;
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("midwait_req", 32'(imem_req), 32'h1);
    wait_cycles = 0;
    do_reset();
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("restart_addr", imem_addr, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("restart_valid", 32'(valid_out), 32'h1);
    chk("restart_pc", pc_out, 32'h0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 32'h0);
    chk("restart_seq_pc", pc_out, 32'h10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the 5-stage pipeline. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched `pc_out`/`instr_out` pair to the IF/ID pipeline register. It honours pipeline stalls from the hazard unit and branch/jump redirects from later stages. It discards any in-flight fetch that a redirect makes stale.

## Interface
- `RESET_PC`, 32'h0000_0000, address of the first fetch after reset; bits [1:0] must be 0.
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting (0) clears all state immediately, release is synchronous to `clk`.
- `stall`  in  1  1 = IF/ID is not accepting; outputs must hold.
- `redirect`  in  1  1 = a taken branch/jump this cycle; flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  memory has the word; `imem_rdata` is valid this cycle; may be high in the first request cycle.
- `imem_rdata`  in  32  instruction word.
- `pc_out`  out  32  PC of the presented instruction; feeds IF/ID `pc_in`.
- `instr_out`  out  32  presented instruction; feeds IF/ID `instr_in`; 0 (NOP) when invalid.
- `valid_out`  out  1  1 = `pc_out`/`instr_out` hold a real instruction.

## Operation
- Registers: `pc`, `state` (IDLE/FETCH/HOLD), `kill`, `kill_pc`, `hold_pc`, `hold_instr`, `pc_out`, `instr_out`, `valid_out`.
- Reset values:
  - `pc`=RESET_PC, state=IDLE, `kill`=0.
  - `pc_out`=0, `instr_out`=0, `valid_out`=0.
  - `imem_req`=0 (`imem_req` is decoded from state).
- `imem_req` = (state==FETCH). `imem_addr` = `pc`.
- Priority in every state: `redirect` > `imem_ack` > `stall`.
- **IDLE**:
  - Unconditionally moves to FETCH.
  - If `redirect`=1, `pc` loads {redirect_pc[31:2],2'b00}.
- **FETCH**:
  - `redirect`=1 with `imem_ack`=1: drop the data; `pc` loads the target; `kill` cleared; `valid_out`/`instr_out` go to 0; stay in FETCH.
  - `redirect`=1 with no ack: the request cannot be cancelled. Set `kill`=1 and `kill_pc`=target; `valid_out`/`instr_out` go to 0; `pc` is unchanged, so the address stays stable.
  - `imem_ack`=1 with `kill`=1: drop the data; `pc` loads `kill_pc`; `kill` clears; `valid_out` stays 0.
  - `imem_ack`=1, `stall`=0: `pc_out`<=`pc`, `instr_out`<=`imem_rdata`, `valid_out`<=1; `pc`<=`pc`+4; stay in FETCH.
  - `imem_ack`=1, `stall`=1: outputs hold. `hold_pc`<=`pc`, `hold_instr`<=`imem_rdata`; `pc`<=`pc`+4; go to HOLD.
  - No ack, `stall`=0: `valid_out`<=0 and `instr_out`<=0 (bubble); `pc_out` holds.
  - No ack, `stall`=1: outputs hold.
- **HOLD** (`imem_req`=0):
  - `redirect`=1: discard the buffer; `pc` loads the target; `valid_out`/`instr_out` go to 0; go to FETCH.
  - `stall`=1: outputs hold.
  - `stall`=0: `pc_out`<=`hold_pc`, `instr_out`<=`hold_instr`, `valid_out`<=1; go to FETCH.
- A redirect flushes the outputs even while `stall`=1.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0. `pc[1:0]` is always 00.

## Timing
- After reset release: cycle 0 is IDLE; cycle 1 is the first request at RESET_PC.
- With zero-wait memory (ack in the request cycle), `valid_out`=1 with `pc_out`=RESET_PC in cycle 2. Throughput is then one instruction per cycle.
- A memory wait of N cycles gives N bubble cycles (`valid_out`=0) when not stalled.
- Redirect to first valid target instruction, zero-wait memory: 2 cycles (redirect in cycle t, request at target in t+1, valid in t+2).
- An outstanding killed request adds its remaining wait cycles plus 1.
- In HOLD, the buffered instruction appears the cycle after `stall` falls; the next request issues that same cycle.
- Reset asserted mid-fetch: `imem_req` drops asynchronously, and the pending ack is ignored after release.

## Test plan
- Reset release, zero-wait ROM with word[i]=i: `valid_out` rises in cycle 2; `pc_out` sequence is 0,4,8,… with `instr_out`=0,1,2,….
- Memory with 2-cycle wait: each instruction is separated by 2 bubbles (`valid_out`=0, `instr_out`=0); `imem_addr` stays stable while waiting.
- `stall` held 3 cycles after `pc_out`=8 is accepted: `pc_out`/`instr_out` hold at 8 while address 12 is buffered; `imem_req`=0. On release, `pc_out`=12 next cycle with no lost or duplicated word.
- `redirect`=1 with `redirect_pc`=32'h0000_0103 while a 3-cycle fetch of 0x20 is in flight: the 0x20 data is dropped; the next request is at 0x100; the first valid output is `pc_out`=0x100.
- `redirect` and `stall` both high in HOLD: outputs are flushed (`valid_out`=0), the buffer is discarded, and fetch resumes at the target.
- `pc` at 32'hFFFF_FFFC fetched with ack: the next `imem_addr` is 0. Asserting `reset` mid-wait forces all outputs to 0 immediately, and fetch restarts at RESET_PC.
